note_scroller: RTL

//  Scroll engine feeding drawNode: fetches a note chart from synchronous ROM, keeps a 10-cell

---
 rtl/note_pkg.sv | 34 +++
 rtl/step_timer.sv | 45 ++++
 rtl/note_scroller.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/note_pkg.sv
// Shared definitions for the note scroller.
//   NUM_CELLS  : cells in the visible note window
//   CELL_PX    : pixels per cell; offset runs 0..CELL_PX-1
//   OFFSET_MAX : last sub-cell offset before a cell shift
//   state_e    : scroller FSM states
//   NOTE_*     : chart entry / cell encodings, {red,blue}
//   norm_note  : folds a raw chart entry into a legal cell value
package note_pkg;

  localparam int NUM_CELLS  = 10;
  localparam int CELL_PX    = 7;
  localparam int OFFSET_MAX = CELL_PX - 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    PAUSE = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam logic [1:0] NOTE_NONE = 2'b00;
  localparam logic [1:0] NOTE_RED  = 2'b10;
  localparam logic [1:0] NOTE_BLUE = 2'b01;

  // An entry with both bits set is kept as red only, so a cell is never
  // red and blue at the same time.
  function automatic logic [1:0] norm_note(input logic [1:0] raw);
    if (raw[1])      return NOTE_RED;
    else if (raw[0]) return NOTE_BLUE;
    else             return NOTE_NONE;
  endfunction

endpackage

// File: rtl/step_timer.sv
// Pixel-step prescaler.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous return of the count to 0
//   enable     : count while high, hold the count while low
//   speed      : period = STEP_DIV >> speed
//   step       : 1-clk pulse on the terminal count
// The terminal test is ">=" so that a speed change that shortens the period
// below the current count produces a step on the very next enabled clock.
module step_timer #(
  parameter int STEP_DIV = 1_250_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       enable,
  input  logic [1:0] speed,
  output logic       step
);

  localparam int CNT_W = $clog2(STEP_DIV);
  localparam logic [CNT_W:0] DIV_L = (CNT_W+1)'(STEP_DIV);

  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   period;
  logic [CNT_W:0]   period_m1;

  always_comb begin
    period    = DIV_L >> speed;
    period_m1 = period - 1'b1;
    step      = enable && ({1'b0, count} >= period_m1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (step) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/note_scroller.sv
// Scroll engine for the note display.
//   start/pause/speed      : song control (start is a pulse, pause a level)
//   chart_addr/chart_data  : synchronous chart ROM, data valid 1 clk after addr
//   hit_valid/hit_red      : player press and which button
//   red_notes/blue_notes   : 10-cell window, bit i = cell i
//   offset                 : sub-cell pixel offset 0..6
//   hit_ok/hit_bad/miss    : 1-clk judgement pulses
//   busy/song_done         : song status levels
//   dbg_state              : current FSM state, for observation only
// Every output is a register; the window and offset update on the same edge.
// Inputs are plain levels/pulses sampled on the rising edge; there is no
// back-pressure anywhere in this block.
module note_scroller
  import note_pkg::*;
#(
  parameter int STEP_DIV   = 1_250_000,
  parameter int CHART_LEN  = 256,
  parameter int ADDR_W     = 8,
  parameter int JUDGE_CELL = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 pause,
  input  logic [1:0]           speed,
  output logic [ADDR_W-1:0]    chart_addr,
  input  logic [1:0]           chart_data,
  input  logic                 hit_valid,
  input  logic                 hit_red,
  output logic [NUM_CELLS-1:0] red_notes,
  output logic [NUM_CELLS-1:0] blue_notes,
  output logic [2:0]           offset,
  output logic                 hit_ok,
  output logic                 hit_bad,
  output logic                 miss,
  output logic                 busy,
  output logic                 song_done,
  output logic [2:0]           dbg_state
);

  state_e state, state_nx;

  // pf_cnt: 2 = address 0 just issued, 1 = ROM data valid this clock, 0 = done
  logic [1:0]           pf_cnt;
  logic [1:0]           next_note;
  logic                 next_is_last;
  logic                 step;
  logic                 cell_shift;
  logic                 start_ok;
  logic                 active;
  logic                 tmr_en;
  logic                 hit_take;
  logic                 hit_match;
  logic                 last_addr;
  logic [1:0]           in_note;
  logic [NUM_CELLS-1:0] clr_mask;
  logic [NUM_CELLS-1:0] red_c;
  logic [NUM_CELLS-1:0] blue_c;

  step_timer #(.STEP_DIV(STEP_DIV)) u_step_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (start_ok),
    .enable (tmr_en),
    .speed  (speed),
    .step   (step)
  );

  always_comb begin
    start_ok   = start && ((state == IDLE) || (state == DONE));
    active     = (state == RUN) || (state == PAUSE) || (state == DRAIN);
    tmr_en     = ((state == RUN) || (state == DRAIN)) && !pause && (pf_cnt == 2'd0);
    cell_shift = step && (offset == 3'(OFFSET_MAX));
    last_addr  = (chart_addr == ADDR_W'(CHART_LEN - 1));
    in_note    = (state == DRAIN) ? NOTE_NONE : next_note;

    // Judge against the window as it stands before this edge's update; a
    // matching hit clears the cell before any shift is applied, so a cleared
    // note can never be reported as a miss.
    hit_take  = hit_valid && active;
    hit_match = hit_red ? red_notes[JUDGE_CELL] : blue_notes[JUDGE_CELL];
    clr_mask  = '0;
    if (hit_take && hit_match) clr_mask[JUDGE_CELL] = 1'b1;
    red_c  = red_notes  & ~clr_mask;
    blue_c = blue_notes & ~clr_mask;
  end

  // FSM next state
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (start) state_nx = RUN;
      RUN: begin
        if (pause)                              state_nx = PAUSE;
        else if (cell_shift && next_is_last)    state_nx = DRAIN;
      end
      PAUSE: if (!pause) state_nx = RUN;
      DRAIN: begin
        // Nothing enters in DRAIN, so the post-shift window is cells 9..1.
        if (cell_shift && (red_c[NUM_CELLS-1:1] == '0) && (blue_c[NUM_CELLS-1:1] == '0))
          state_nx = DONE;
      end
      DONE:  if (start) state_nx = RUN;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Fetch, window and offset datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chart_addr   <= '0;
      pf_cnt       <= 2'd0;
      next_note    <= NOTE_NONE;
      next_is_last <= 1'b0;
      red_notes    <= '0;
      blue_notes   <= '0;
      offset       <= 3'd0;
    end else if (start_ok) begin
      chart_addr   <= '0;
      pf_cnt       <= 2'd2;
      next_note    <= NOTE_NONE;
      next_is_last <= 1'b0;
      red_notes    <= '0;
      blue_notes   <= '0;
      offset       <= 3'd0;
    end else begin
      red_notes  <= red_c;
      blue_notes <= blue_c;

      if (pf_cnt != 2'd0) begin
        pf_cnt <= pf_cnt - 2'd1;
        if (pf_cnt == 2'd1) begin
          next_note    <= norm_note(chart_data);
          next_is_last <= last_addr;
          if (!last_addr) chart_addr <= chart_addr + 1'b1;
        end
      end

      if (step) begin
        offset <= cell_shift ? 3'd0 : offset + 3'd1;
      end

      if (cell_shift) begin
        red_notes  <= {in_note[1], red_c[NUM_CELLS-1:1]};
        blue_notes <= {in_note[0], blue_c[NUM_CELLS-1:1]};
        if (state == RUN) begin
          next_note    <= norm_note(chart_data);
          next_is_last <= last_addr;
          if (!last_addr) chart_addr <= chart_addr + 1'b1;
        end
      end
    end
  end

  // Pulses and status levels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_ok    <= 1'b0;
      hit_bad   <= 1'b0;
      miss      <= 1'b0;
      busy      <= 1'b0;
      song_done <= 1'b0;
    end else begin
      hit_ok    <= hit_take && hit_match;
      hit_bad   <= hit_take && !hit_match;
      miss      <= cell_shift && (red_c[0] || blue_c[0]);
      busy      <= (state_nx == RUN) || (state_nx == PAUSE) || (state_nx == DRAIN);
      song_done <= (state_nx == DONE);
    end
  end

  assign dbg_state = state;

endmodule
